// File: rtl/comp_fiber_pkg.sv
// Shared constants, state encoding and PRBS step for the comparator fiber link.
// Used by both the transmit framer and the receive-side checker.
package comp_fiber_pkg;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam logic [7:0] K28_7  = 8'hFC;
  localparam logic [7:0] D_DATA = 8'h50;
  localparam logic [7:0] D_IDLE = 8'hC5;

  localparam logic [47:0] PRBS_SEED = 48'hFFFF_FF00_0000;
  // x^48 + x^47 + x^21 + x^20 + 1
  localparam logic [47:0] PRBS_TAPS = 48'hC000_0018_0000;
  localparam int PRBS_STEPS = 48;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } tx_state_t;

  function automatic logic [47:0] prbs_advance(
    input logic [47:0] s
  );
    logic [47:0] r;
    r = s;
    for (int i = 0; i < PRBS_STEPS; i++) begin
      r = {r[46:0], ^(r & PRBS_TAPS)};
    end
    return r;
  endfunction

endpackage

// File: rtl/comp_fiber_tx_framer_prbs.sv
// Frame-rate PRBS generator: one 48-bit payload per CE,
// advancing 48 LFSR steps per frame; held at seed while RESEED.
module prbs_tx_c160
  import comp_fiber_pkg::*;
(
  input  logic        CMP_TX_CLK160,
  input  logic        RST_N,
  input  logic        CE,
  input  logic        RESEED,
  output logic [47:0] PRBS_Q
);

  always_ff @(posedge CMP_TX_CLK160) begin
    if (!RST_N) begin
      PRBS_Q <= PRBS_SEED;
    end else if (RESEED) begin
      PRBS_Q <= PRBS_SEED;
    end else if (CE) begin
      PRBS_Q <= prbs_advance(PRBS_Q);
    end
  end

endmodule

// File: rtl/comp_fiber_tx_framer.sv
// Comparator fiber TX framer: sync word + three data words per frame.
// Optional PRBS payload source is built when CMP_TX_PRBS_EN is defined.
module comp_fiber_tx_framer
  import comp_fiber_pkg::*;
#(
  parameter int ALIGN_FRAMES = 256
) (
  input  logic        CMP_TX_CLK160,
  input  logic        RST_N,
  input  logic        TX_SYNC_DONE,
  input  logic [47:0] TX_DATA,
  input  logic        TX_VALID,
  output logic        TX_READY,
  input  logic        LTNCY_TRIG,
  output logic        LT_OVERFLOW,
  output logic [15:0] TXDATA,
  output logic [1:0]  TXCHARISK,
  output logic        FRAME_STRT,
`ifdef CMP_TX_PRBS_EN
  input  logic        PRBS_MODE,
`endif
  output logic        ALIGNED
);

  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_FRAMES - 1);

  tx_state_t   state, state_n;
  logic [1:0]  wc, wc_n;
  logic [15:0] acnt, acnt_n;
  logic [47:0] frame, frame_n;
  logic        data_fr, data_n;
  logic        pend, pend_n;
  logic        load, accept, abort;
  logic        ovf_n, ready_n;
  logic [15:0] word_n;
  logic [1:0]  k_n;
  logic        prbs_on, prbs_load;
  logic [47:0] prbs_q;

`ifdef CMP_TX_PRBS_EN
  logic prbs_reseed;

  assign prbs_on     = PRBS_MODE;
  assign prbs_load   = load & (state == RUN)
                     & TX_SYNC_DONE & PRBS_MODE;
  assign prbs_reseed = ~((state == RUN) & PRBS_MODE);

  prbs_tx_c160 u_prbs (
    .CMP_TX_CLK160 (CMP_TX_CLK160),
    .RST_N         (RST_N),
    .CE            (prbs_load),
    .RESEED        (prbs_reseed),
    .PRBS_Q        (prbs_q)
  );
`else
  assign prbs_on   = 1'b0;
  assign prbs_load = 1'b0;
  assign prbs_q    = '0;
`endif

  always_comb begin
    wc_n    = wc + 2'd1;
    load    = (wc == 2'd3);
    accept  = TX_READY & TX_VALID;
    abort   = (state != WAIT) & ~TX_SYNC_DONE;
    state_n = state;
    acnt_n  = acnt;
    unique case (state)
      WAIT: begin
        if (TX_SYNC_DONE) begin
          state_n = ALIGN;
          acnt_n  = '0;
        end
      end
      ALIGN: begin
        if (!TX_SYNC_DONE) begin
          state_n = WAIT;
        end else if (load) begin
          if (acnt == ALIGN_LAST) state_n = RUN;
          else acnt_n = acnt + 16'd1;
        end
      end
      RUN: begin
        if (!TX_SYNC_DONE) state_n = WAIT;
      end
      default: state_n = WAIT;
    endcase

    // Handshake data wins at the boundary; a link drop only
    // blanks the words of the frame still in flight.
    frame_n = frame;
    data_n  = data_fr;
    if (accept) begin
      frame_n = TX_DATA;
      data_n  = 1'b1;
    end else if (prbs_load) begin
      frame_n = prbs_q;
      data_n  = 1'b1;
    end else if (load || abort) begin
      frame_n = '0;
      data_n  = 1'b0;
    end

    pend_n = load ? LTNCY_TRIG : (pend | LTNCY_TRIG);
    ovf_n  = LTNCY_TRIG & pend & ~load;

    word_n = 16'h0000;
    k_n    = 2'b00;
    unique case (wc_n)
      2'd0: begin
        word_n = {data_n ? D_DATA : D_IDLE,
                  pend ? K28_7 : K28_5};
        k_n    = 2'b01;
      end
      2'd1: word_n = frame_n[15:0];
      2'd2: word_n = frame_n[31:16];
      2'd3: word_n = frame_n[47:32];
      default: word_n = 16'h0000;
    endcase

    ready_n = (wc == 2'd2) & (state_n == RUN) & ~prbs_on;
  end

  always_ff @(posedge CMP_TX_CLK160) begin
    if (!RST_N) begin
      state       <= WAIT;
      wc          <= 2'd0;
      acnt        <= '0;
      frame       <= '0;
      data_fr     <= 1'b0;
      pend        <= 1'b0;
      TXDATA      <= {D_IDLE, K28_5};
      TXCHARISK   <= 2'b01;
      FRAME_STRT  <= 1'b1;
      TX_READY    <= 1'b0;
      ALIGNED     <= 1'b0;
      LT_OVERFLOW <= 1'b0;
    end else begin
      state       <= state_n;
      wc          <= wc_n;
      acnt        <= acnt_n;
      frame       <= frame_n;
      data_fr     <= data_n;
      pend        <= pend_n;
      TXDATA      <= word_n;
      TXCHARISK   <= k_n;
      FRAME_STRT  <= (wc_n == 2'd0);
      TX_READY    <= ready_n;
      ALIGNED     <= (state_n == RUN);
      LT_OVERFLOW <= ovf_n;
    end
  end

endmodule

// File: tb/tb_comp_fiber_tx_framer.sv
// Randomized bench for comp_fiber_tx_framer against a
// frame-level reference model.
module tb_comp_fiber_tx_framer;

  localparam int AF = 4;
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_done;
  logic [47:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        trig;
  logic        lt_ovf;
  logic [15:0] txdata;
  logic [1:0]  charisk;
  logic        frame_strt;
  logic        aligned;
`ifdef CMP_TX_PRBS_EN
  logic        prbs_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  comp_fiber_tx_framer #(.ALIGN_FRAMES(AF)) dut (
    .CMP_TX_CLK160 (clk),
    .RST_N         (rst_n),
    .TX_SYNC_DONE  (sync_done),
    .TX_DATA       (tx_data),
    .TX_VALID      (tx_valid),
    .TX_READY      (tx_ready),
    .LTNCY_TRIG    (trig),
    .LT_OVERFLOW   (lt_ovf),
    .TXDATA        (txdata),
    .TXCHARISK     (charisk),
    .FRAME_STRT    (frame_strt),
`ifdef CMP_TX_PRBS_EN
    .PRBS_MODE     (prbs_mode),
`endif
    .ALIGNED       (aligned)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, obs, exp);
    end
  endtask

  // Reference: t = cycles since reset, fr = the four words of
  // the current frame, mode 0/1/2 = down/aligning/running.
  int          t;
  logic [15:0] fr[4];
  int          mode;
  int          nfr;
  bit          m_pend;
  bit          e_ovf;
  bit          e_ready;

  task automatic model_edge();
    bit bnd, acc, fck, abort;
    if (!rst_n) begin
      t = 0;
      fr = '{16'hC5BC, 16'h0, 16'h0, 16'h0};
      mode = 0;
      nfr = 0;
      m_pend = 0;
      e_ovf = 0;
      e_ready = 0;
      return;
    end
    bnd = (t % 4 == 3);
    acc = e_ready && tx_valid;
    e_ovf = trig && m_pend && !bnd;
    fck = m_pend;
    if (bnd) m_pend = trig;
    else m_pend = m_pend || trig;
    abort = 0;
    if (mode == 0) begin
      if (sync_done) begin
        mode = 1;
        nfr = 0;
      end
    end else if (!sync_done) begin
      mode = 0;
      abort = 1;
    end else if (mode == 1 && bnd) begin
      nfr++;
      if (nfr == AF) mode = 2;
    end
    if (bnd) begin
      fr[0] = {acc ? 8'h50 : 8'hC5, fck ? 8'hFC : 8'hBC};
      fr[1] = acc ? tx_data[15:0] : 16'h0;
      fr[2] = acc ? tx_data[31:16] : 16'h0;
      fr[3] = acc ? tx_data[47:32] : 16'h0;
    end else if (abort) begin
      for (int k = t % 4 + 1; k < 4; k++) fr[k] = 16'h0;
    end
    t++;
    e_ready = (mode == 2) && (t % 4 == 3);
  endtask

  task automatic check_all();
    chk("txdata", 48'(txdata), 48'(fr[t % 4]));
    chk("charisk", 48'(charisk),
        48'((t % 4 == 0) ? 2'b01 : 2'b00));
    chk("frame_strt", 48'(frame_strt), 48'(t % 4 == 0));
    chk("tx_ready", 48'(tx_ready), 48'(e_ready));
    chk("aligned", 48'(aligned), 48'(mode == 2));
    chk("lt_overflow", 48'(lt_ovf), 48'(e_ovf));
  endtask

  int low_left = 0;

  initial begin
    rst_n = 1'b0;
    sync_done = 1'b0;
    tx_data = '0;
    tx_valid = 1'b0;
    trig = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc < 3) rst_n = 1'b0;
      else rst_n = !(cyc > 200 && $urandom_range(0, 199) == 0);
      if (cyc < 13) begin
        sync_done = 1'b0;
      end else if (cyc <= 200) begin
        sync_done = 1'b1;
      end else if (low_left > 0) begin
        low_left--;
        sync_done = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        low_left = $urandom_range(1, 30);
        sync_done = 1'b0;
      end else begin
        sync_done = 1'b1;
      end
      tx_valid = (cyc < 200) ? 1'b1 : 1'($urandom_range(0, 1));
      if (cyc < 300) tx_data = 48'h1234_5678_9ABC;
      else tx_data = {16'($urandom), 32'($urandom)};
      trig = ($urandom_range(0, 5) == 0);
      model_edge();
      @(negedge clk);
      check_all();
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
